// File: rtl/epass_pkg.sv
// epass_pkg: shared definitions for the e-pass toll checker.
//   state_t  - FSM state encodings (also visible on the state_dbg port)
//   VERDICT_* - codes driven on valid_Epass
//   entry_t  - account table entry {active, balance}
//   FEE_DEFAULT / SITE_CODE_DEFAULT - default toll and site nibble
package epass_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_DEDUCT = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] VERDICT_BUSY = 2'b00;
  localparam logic [1:0] VERDICT_OK   = 2'b10;
  localparam logic [1:0] VERDICT_BAD  = 2'b01;

  localparam logic [7:0] FEE_DEFAULT       = 8'd5;
  localparam logic [3:0] SITE_CODE_DEFAULT = 4'hA;

  typedef struct packed {
    logic       active;
    logic [7:0] balance;
  } entry_t;

endpackage

// File: rtl/epass_checker_tag_shifter.sv
// tag_shifter: serial-to-parallel capture of the pass tag, MSB first.
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - zero the bit counter and shift register
//   strobe       - qualifies bit_in for one cycle (already gated by caller)
//   bit_in       - serial tag data
//   tag          - captured tag
//   done         - combinational pulse, high on the strobe that completes
//                  the tag so the FSM can leave SHIFT on that same edge
module tag_shifter #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             strobe,
  input  logic             bit_in,
  output logic [TAG_W-1:0] tag,
  output logic             done
);

  localparam int CNT_W = $clog2(TAG_W + 1);

  logic [TAG_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (strobe && (cnt_q < CNT_W'(TAG_W))) begin
      // Strobes past a full tag are dropped: the counter saturates.
      shift_d = {shift_q[TAG_W-2:0], bit_in};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tag  = shift_q;
  assign done = strobe && !clear && (cnt_q == CNT_W'(TAG_W - 1));

endmodule

// File: rtl/epass_checker.sv
// epass_checker: validates a serially delivered pass tag against a 16-entry
// account table and deducts a toll from valid accounts.
//   clk, reset_n          - clock, asynchronous active-low reset
//   cal                   - validation request level (held until response)
//   tag_strobe, tag_bit   - serial tag, MSB first
//   wr_en/wr_addr/wr_data - account table write {active, balance}
//   wr_busy               - table write would be dropped this cycle
//   valid_Epass           - 00 busy/idle, 10 valid, 01 invalid
//   balance_out           - balance of the last checked account
//   state_dbg             - current FSM state
// Handshake: cal rises to start a request; the verdict on valid_Epass is
// held for as long as cal stays high, and cal falling returns to idle.
// Optional macro EPASS_TIMEOUT_EN: adds a SHIFT-state cycle counter; after
// TIMEOUT_CYC cycles without a complete tag the request answers 01.
module epass_checker
  import epass_pkg::*;
#(
  parameter int         TAG_W       = 8,
  parameter logic [3:0] SITE_CODE   = SITE_CODE_DEFAULT,
  parameter logic [7:0] FEE         = FEE_DEFAULT,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cal,
  input  logic       tag_strobe,
  input  logic       tag_bit,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [8:0] wr_data,
  output logic       wr_busy,
  output logic [1:0] valid_Epass,
  output logic [7:0] balance_out,
  output logic [2:0] state_dbg
);

  state_t           state_q, state_d;
  logic             cal_q;
  logic [1:0]       verdict_q, verdict_d;
  logic [7:0]       bal_q, bal_d;
  entry_t           table_q [16];
  entry_t           table_d [16];

  logic             shift_clear;
  logic [TAG_W-1:0] tag;
  logic             shift_done;
  logic             timeout_hit;
  logic [3:0]       idx;
  entry_t           cur_entry;
  logic             lookup_ok;

  tag_shifter #(.TAG_W(TAG_W)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (shift_clear),
    .strobe  (tag_strobe && (state_q == ST_SHIFT)),
    .bit_in  (tag_bit),
    .tag     (tag),
    .done    (shift_done)
  );

`ifdef EPASS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts cycles spent in SHIFT; zero whenever the FSM is elsewhere.
  always_comb begin
    tmo_cnt_d = (state_q == ST_SHIFT) ? tmo_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = (state_q == ST_SHIFT) &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign idx       = tag[3:0];
  assign cur_entry = table_q[idx];
  assign lookup_ok = (tag[TAG_W-1 -: 4] == SITE_CODE) && cur_entry.active &&
                     (cur_entry.balance >= FEE);
  // Table writes are blocked while the selected entry is being evaluated.
  assign wr_busy   = (state_q == ST_LOOKUP) || (state_q == ST_DEDUCT);

  always_comb begin
    state_d     = state_q;
    verdict_d   = verdict_q;
    bal_d       = bal_q;
    table_d     = table_q;
    shift_clear = 1'b0;

    if (wr_en && !wr_busy) table_d[wr_addr] = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (cal && !cal_q) begin
          state_d     = ST_SHIFT;
          shift_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!cal)             state_d = ST_IDLE;
        else if (shift_done)  state_d = ST_LOOKUP;
        else if (timeout_hit) begin
          state_d   = ST_RESP;
          verdict_d = VERDICT_BAD;
        end
      end
      ST_LOOKUP: begin
        if (!cal)           state_d = ST_IDLE;
        else if (lookup_ok) state_d = ST_DEDUCT;
        else begin
          state_d   = ST_RESP;
          verdict_d = VERDICT_BAD;
          bal_d     = cur_entry.balance;
        end
      end
      ST_DEDUCT: begin
        // Entering DEDUCT commits the toll; LOOKUP guaranteed no underflow.
        table_d[idx].balance = cur_entry.balance - FEE;
        bal_d                = cur_entry.balance - FEE;
        if (!cal) state_d = ST_IDLE;
        else begin
          state_d   = ST_RESP;
          verdict_d = VERDICT_OK;
        end
      end
      ST_RESP: begin
        if (!cal) begin
          state_d   = ST_IDLE;
          verdict_d = VERDICT_BUSY;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        verdict_d = VERDICT_BUSY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cal_q     <= 1'b0;
      verdict_q <= VERDICT_BUSY;
      bal_q     <= 8'h00;
      for (int i = 0; i < 16; i++) table_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cal_q     <= cal;
      verdict_q <= verdict_d;
      bal_q     <= bal_d;
      for (int i = 0; i < 16; i++) table_q[i] <= table_d[i];
    end
  end

  assign valid_Epass = verdict_q;
  assign balance_out = bal_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_epass_checker.sv
// tb_epass_checker: vector table of single transactions plus hand-written
// sequences for abort, write blocking, timeout and reset corner cases.
module tb_epass_checker;
  import epass_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cal = 1'b0;
  logic       tag_strobe = 1'b0;
  logic       tag_bit = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [8:0] wr_data = '0;
  logic       wr_busy;
  logic [1:0] valid_Epass;
  logic [7:0] balance_out;
  logic [2:0] state_dbg;

  int n_vec  = 0;
  int n_fail = 0;
  string lbl = "init";

  // Scoreboard entry: {latency[3:0], verdict[1:0], balance[7:0]}
  logic [13:0] exp_q[$];

  typedef struct {
    bit         do_wr;
    logic [3:0] wa;
    logic [8:0] wd;
    logic [7:0] tag;
    logic [1:0] exp_v;
    logic [7:0] exp_bal;
    logic [8:0] exp_entry;
  } vec_t;

  vec_t vecs[9];

  epass_checker #(.TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cal         (cal),
    .tag_strobe  (tag_strobe),
    .tag_bit     (tag_bit),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_busy     (wr_busy),
    .valid_Epass (valid_Epass),
    .balance_out (balance_out),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", lbl, name, act, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [8:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Full request: raise cal, shift 8 bits, measure latency from the edge
  // that samples the last strobe, compare against the scoreboard, then
  // drop cal and check the return to idle.
  task automatic run_txn(input logic [7:0] tag, input bit shift_wr,
                         input logic [3:0] swa, input logic [8:0] swd,
                         input bit busy_wr);
    logic [13:0] e;
    int lat;
    @(negedge clk);
    cal = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tag_strobe = 1'b1;
      tag_bit    = tag[7-i];
      if (shift_wr && i == 4) begin
        wr_en = 1'b1; wr_addr = swa; wr_data = swd;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    tag_strobe = 1'b0;
    wr_en      = 1'b0;
    lat = 1;
    while (valid_Epass == 2'b00 && lat < 8) begin
      if (busy_wr) begin
        wr_en = (lat == 2);
        wr_addr = 4'd4; wr_data = {1'b1, 8'd99};
        if (lat == 2) check("wr_busy_deduct", {31'd0, wr_busy}, 32'd1);
      end
      @(negedge clk);
      lat++;
    end
    wr_en = 1'b0;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("latency", lat, {28'd0, e[13:10]});
    check("verdict", {30'd0, valid_Epass}, {30'd0, e[9:8]});
    check("balance", {24'd0, balance_out}, {24'd0, e[7:0]});
    @(negedge clk);
    @(negedge clk);
    check("verdict_held", {30'd0, valid_Epass}, {30'd0, e[9:8]});
    cal = 1'b0;
    @(negedge clk);
    check("verdict_cleared", {30'd0, valid_Epass}, 32'd0);
    check("back_idle", {29'd0, state_dbg}, {29'd0, ST_IDLE});
  endtask

  function automatic logic [13:0] sb_word(input logic [1:0] v, input logic [7:0] b);
    logic [3:0] l;
    l = (v == VERDICT_OK) ? 4'd3 : 4'd2;
    return {l, v, b};
  endfunction

  initial begin
    logic [7:0] rb;
    rb = 8'($urandom_range(5, 255));
    //          wr  addr  data          tag     verdict      bal        entry after
    vecs[0] = '{1'b1, 4'd3,  {1'b1, 8'd20},  8'hA3, VERDICT_OK,  8'd15,   {1'b1, 8'd15}};
    vecs[1] = '{1'b0, 4'd0,  9'd0,           8'hB3, VERDICT_BAD, 8'd15,   {1'b1, 8'd15}};
    vecs[2] = '{1'b1, 4'd5,  {1'b1, 8'd4},   8'hA5, VERDICT_BAD, 8'd4,    {1'b1, 8'd4}};
    vecs[3] = '{1'b1, 4'd5,  {1'b0, 8'd50},  8'hA5, VERDICT_BAD, 8'd50,   {1'b0, 8'd50}};
    vecs[4] = '{1'b1, 4'd7,  {1'b1, 8'd5},   8'hA7, VERDICT_OK,  8'd0,    {1'b1, 8'd0}};
    vecs[5] = '{1'b0, 4'd0,  9'd0,           8'hA7, VERDICT_BAD, 8'd0,    {1'b1, 8'd0}};
    vecs[6] = '{1'b1, 4'd0,  {1'b1, 8'd255}, 8'hA0, VERDICT_OK,  8'd250,  {1'b1, 8'd250}};
    vecs[7] = '{1'b1, 4'd15, {1'b1, 8'd6},   8'hAF, VERDICT_OK,  8'd1,    {1'b1, 8'd1}};
    vecs[8] = '{1'b1, 4'd9,  {1'b1, rb},     8'hA9, VERDICT_OK,  rb - 8'd5, {1'b1, rb - 8'd5}};

    // Reset state
    repeat (3) @(negedge clk);
    lbl = "reset";
    check("valid", {30'd0, valid_Epass}, 32'd0);
    check("balance", {24'd0, balance_out}, 32'd0);
    check("wr_busy", {31'd0, wr_busy}, 32'd0);
    check("state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("entry3", {23'd0, dut.table_q[3]}, 32'd0);
    reset_n = 1'b1;

    // Strobes while idle must not start or disturb anything
    lbl = "idle_strobe";
    @(negedge clk); tag_strobe = 1'b1; tag_bit = 1'b1;
    @(negedge clk); tag_strobe = 1'b0;
    check("state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

    for (int v = 0; v < 9; v++) begin
      lbl = $sformatf("vec%0d", v);
      if (vecs[v].do_wr) write_entry(vecs[v].wa, vecs[v].wd);
      exp_q.push_back(sb_word(vecs[v].exp_v, vecs[v].exp_bal));
      run_txn(vecs[v].tag, 1'b0, 4'd0, 9'd0, 1'b0);
      check("entry", {23'd0, dut.table_q[vecs[v].tag[3:0]]}, {23'd0, vecs[v].exp_entry});
    end

    // Abort after 4 strobes, then a full request on the same entry
    lbl = "abort";
    write_entry(4'd2, {1'b1, 8'd30});
    @(negedge clk); cal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); tag_strobe = 1'b1; tag_bit = (i == 0);
    end
    @(negedge clk); tag_strobe = 1'b0; cal = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("valid", {30'd0, valid_Epass}, 32'd0);
    end
    check("state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("entry2", {23'd0, dut.table_q[2]}, {23'd0, 1'b1, 8'd30});
    lbl = "after_abort";
    exp_q.push_back(sb_word(VERDICT_OK, 8'd25));
    run_txn(8'hA2, 1'b0, 4'd0, 9'd0, 1'b0);

    // Write during DEDUCT is dropped
    lbl = "busy_write";
    exp_q.push_back(sb_word(VERDICT_OK, 8'd20));
    run_txn(8'hA2, 1'b0, 4'd0, 9'd0, 1'b1);
    check("entry4", {23'd0, dut.table_q[4]}, 32'd0);
    check("entry2", {23'd0, dut.table_q[2]}, {23'd0, 1'b1, 8'd20});

    // Write to the checked entry during SHIFT is used by LOOKUP
    lbl = "shift_write";
    exp_q.push_back(sb_word(VERDICT_OK, 8'd35));
    run_txn(8'hA6, 1'b1, 4'd6, {1'b1, 8'd40}, 1'b0);
    check("entry6", {23'd0, dut.table_q[6]}, {23'd0, 1'b1, 8'd35});

    // Timeout with no strobes
    lbl = "timeout";
    @(negedge clk); cal = 1'b1;
    repeat (16) @(negedge clk);
    check("before", {30'd0, valid_Epass}, 32'd0);
    @(negedge clk);
`ifdef EPASS_TIMEOUT_EN
    check("verdict", {30'd0, valid_Epass}, {30'd0, VERDICT_BAD});
`else
    check("verdict", {30'd0, valid_Epass}, 32'd0);
    repeat (20) @(negedge clk);
    check("still_shift", {29'd0, state_dbg}, {29'd0, ST_SHIFT});
`endif
    cal = 1'b0;
    @(negedge clk);
    check("cleared", {30'd0, valid_Epass}, 32'd0);

    // Reset in LOOKUP discards the pending deduction
    lbl = "reset_mid";
    @(negedge clk); cal = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); tag_strobe = 1'b1; tag_bit = (8'hA0 >> (7 - i)) & 8'h1;
    end
    @(negedge clk); tag_strobe = 1'b0;
    check("in_lookup", {29'd0, state_dbg}, {29'd0, ST_LOOKUP});
    reset_n = 1'b0; cal = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("valid", {30'd0, valid_Epass}, 32'd0);
    check("balance", {24'd0, balance_out}, 32'd0);
    check("entry0", {23'd0, dut.table_q[0]}, 32'd0);
    check("state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

    lbl = "end";
    check("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
